// File: rtl/sort_writeback_if.sv
// AXI4 write-only master bundle (AW, W, B) used by sort_writeback.
interface sort_writeback_if #(
  parameter int ID_WIDTH     = 1,
  parameter int AWUSER_WIDTH = 9,
  parameter int DATA_WIDTH   = 1024,
  parameter int ADDR_WIDTH   = 64
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [3:0]              awcache;
  logic                    awlock;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [AWUSER_WIDTH-1:0] awuser;
  logic                    awvalid;
  logic                    awready;

  logic [ID_WIDTH-1:0]     wid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awcache, awlock, awprot, awqos, awuser, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awcache, awlock, awprot, awqos, awuser, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/sort_writeback.sv
// Write-back engine: captures a result vector on start and writes its first
// N beats to host memory as INCR bursts split at MAX_BURST and 4 KB lines.
module sort_writeback #(
  parameter int ID_WIDTH        = 1,
  parameter int AWUSER_WIDTH    = 9,
  parameter int PASID_WIDTH     = 9,
  parameter int DATA_WIDTH      = 1024,
  parameter int ADDR_WIDTH      = 64,
  parameter int RETURN_WIDTH    = 32768,
  parameter int MAX_BURST       = 8,
  parameter int MAX_OUTSTANDING = 4,
  localparam int DEPTH          = RETURN_WIDTH / DATA_WIDTH,
  localparam int BEAT_W         = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    return_start,
  output logic                    return_done,
  output logic                    return_error,
  output logic                    return_busy,
  input  logic [PASID_WIDTH-1:0]  return_pasid,
  input  logic [RETURN_WIDTH-1:0] return_data,
  input  logic [ADDR_WIDTH-1:0]   return_start_addr,
  input  logic [BEAT_W-1:0]       return_beat_num,
  sort_writeback_if.master        m_axi
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [RETURN_WIDTH-1:0] data_q;
  logic [PASID_WIDTH-1:0]  pasid_q;
  logic [ADDR_WIDTH-1:0]   issue_addr_q, aw_addr_q, src_addr;
  logic [BEAT_W-1:0]       issue_rem_q, src_rem, beat_clip;
  logic                    aw_valid_q;
  logic [7:0]              aw_len_q;
  logic [CNT_W-1:0]        outst_q, outst_next, fifo_cnt_q;
  logic [7:0]              fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [7:0]              w_beat_q;
  logic                    error_q;
  logic                    start_ok, aw_hs, w_valid, w_last, w_hs, w_last_hs, b_hs, aw_load;
  logic [31:0]             to_4k, burst_len;
  logic                    unused_bid;

  // Handshakes, outstanding bookkeeping and next-burst sizing.
  // In IDLE the first burst is sized straight from the inputs so that
  // awvalid can rise on the cycle right after the start is accepted.
  always_comb begin
    start_ok   = (state_q == IDLE) && return_start;
    beat_clip  = (return_beat_num > BEAT_W'(DEPTH)) ? BEAT_W'(DEPTH) : return_beat_num;
    aw_hs      = aw_valid_q && m_axi.awready;
    w_valid    = (fifo_cnt_q != '0);
    w_last     = w_valid && (w_beat_q == fifo_mem[rd_ptr_q]);
    w_hs       = w_valid && m_axi.wready;
    w_last_hs  = w_hs && w_last;
    b_hs       = m_axi.bvalid && (outst_q != '0);
    outst_next = outst_q;
    if (aw_hs && !b_hs)      outst_next = outst_q + CNT_W'(1);
    else if (!aw_hs && b_hs) outst_next = outst_q - CNT_W'(1);
    src_addr  = (state_q == IDLE) ? return_start_addr : issue_addr_q;
    src_rem   = (state_q == IDLE) ? beat_clip : issue_rem_q;
    to_4k     = 32'((13'h1000 - {1'b0, src_addr[11:0]}) >> SIZE);
    burst_len = 32'(MAX_BURST);
    if (32'(src_rem) < burst_len) burst_len = 32'(src_rem);
    if (to_4k < burst_len)        burst_len = to_4k;
    if (state_q == IDLE)
      aw_load = start_ok && (beat_clip != '0);
    else
      aw_load = (state_q == RUN) && (issue_rem_q != '0) && (!aw_valid_q || m_axi.awready)
                && (outst_next < CNT_W'(MAX_OUTSTANDING));
  end

  // Next state and job status outputs; RUN ends on the cycle the last B lands.
  always_comb begin
    state_d     = state_q;
    return_done = (state_q == DONE);
    return_busy = (state_q != IDLE);
    case (state_q)
      IDLE: if (start_ok) state_d = (beat_clip == '0) ? DONE : RUN;
      RUN:  if ((issue_rem_q == '0) && !aw_valid_q && (outst_next == '0)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // AW payload register and the cursor of the next burst still to issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_valid_q   <= 1'b0;
      aw_addr_q    <= '0;
      aw_len_q     <= '0;
      issue_addr_q <= '0;
      issue_rem_q  <= '0;
    end else if (aw_load) begin
      aw_valid_q   <= 1'b1;
      aw_addr_q    <= src_addr;
      aw_len_q     <= 8'(burst_len - 32'd1);
      issue_addr_q <= src_addr + (ADDR_WIDTH'(burst_len) << SIZE);
      issue_rem_q  <= src_rem - BEAT_W'(burst_len);
    end else if (aw_hs) begin
      aw_valid_q   <= 1'b0;
    end
  end

  // Burst-length FIFO pointers, W beat counter, outstanding count and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      w_beat_q   <= '0;
      outst_q    <= '0;
      error_q    <= 1'b0;
    end else if (start_ok) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      w_beat_q   <= '0;
      outst_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      outst_q <= outst_next;
      if (aw_hs)
        wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (w_last_hs)
        rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      if (aw_hs && !w_last_hs)      fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
      else if (!aw_hs && w_last_hs) fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
      if (w_hs) w_beat_q <= w_last ? '0 : w_beat_q + 8'd1;
      if (b_hs && (m_axi.bresp != 2'b00)) error_q <= 1'b1;
    end
  end

  // Burst-length storage, written in AW order and read by the W channel.
  always_ff @(posedge clk) begin
    if (aw_hs) fifo_mem[wr_ptr_q] <= aw_len_q;
  end

  // Captured result vector; each W handshake exposes the next slice.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      data_q  <= return_data;
      pasid_q <= return_pasid;
    end else if (w_hs) begin
      data_q  <= data_q >> DATA_WIDTH;
    end
  end

  assign unused_bid    = ^m_axi.bid;
  assign return_error  = error_q;

  assign m_axi.awid    = '0;
  assign m_axi.awaddr  = aw_addr_q;
  assign m_axi.awlen   = aw_len_q;
  assign m_axi.awsize  = 3'(SIZE);
  assign m_axi.awburst = 2'b01;
  assign m_axi.awcache = 4'd3;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awprot  = '0;
  assign m_axi.awqos   = '0;
  assign m_axi.awuser  = AWUSER_WIDTH'(pasid_q);
  assign m_axi.awvalid = aw_valid_q;
  assign m_axi.wid     = '0;
  assign m_axi.wdata   = data_q[DATA_WIDTH-1:0];
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = w_last;
  assign m_axi.wvalid  = w_valid;
  assign m_axi.bready  = 1'b1;
endmodule

// File: tb/tb_sort_writeback.sv
// Directed bench for sort_writeback: AXI slave model, bus log and checks.
module tb_sort_writeback;
  localparam int DW    = 1024;
  localparam int RW    = 32768;
  localparam int AW    = 64;
  localparam int DEPTH = RW / DW;
  localparam int BW    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          return_start = 1'b0;
  logic          return_done, return_error, return_busy;
  logic [8:0]    return_pasid = '0;
  logic [RW-1:0] return_data = '0;
  logic [AW-1:0] return_start_addr = '0;
  logic [BW-1:0] return_beat_num = '0;

  sort_writeback_if #(.ID_WIDTH(1), .AWUSER_WIDTH(9), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi ();

  sort_writeback #(
    .ID_WIDTH(1), .AWUSER_WIDTH(9), .PASID_WIDTH(9), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .RETURN_WIDTH(RW), .MAX_BURST(8), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .return_start(return_start), .return_done(return_done),
    .return_error(return_error), .return_busy(return_busy), .return_pasid(return_pasid),
    .return_data(return_data), .return_start_addr(return_start_addr),
    .return_beat_num(return_beat_num), .m_axi(axi)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] slice(input int unsigned seed, input int unsigned k);
    logic [DW-1:0] v;
    for (int unsigned w = 0; w < DW / 32; w++) v[w*32 +: 32] = {8'(seed), 8'(k), 8'(w), 8'h5A};
    return v;
  endfunction

  // Bus log and slave-model state.
  int unsigned   cyc = 0;
  logic [AW-1:0] aw_addr_log[$];
  int unsigned   aw_len_log[$];
  int unsigned   aw_cyc_log[$];
  logic [DW-1:0] w_data_log[$];
  logic          w_last_log[$];
  int unsigned   b_cyc_log[$];
  int unsigned   done_cnt = 0;
  int unsigned   b_owed = 0, b_sent = 0, b_allow = 1000000, err_at = 0;
  logic          rand_stall = 1'b0;
  logic          stall_aw = 1'b0, stall_w = 1'b0;
  logic [AW-1:0] prev_awaddr;
  logic [7:0]    prev_awlen;
  logic [DW-1:0] prev_wdata;
  logic          prev_wlast;
  logic [63:0]   exp_addr[$];
  int unsigned   exp_len[$];

  // Bus monitor: logs handshakes that complete on the next rising edge and
  // checks that stalled payloads are held.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (stall_aw) begin
        check("aw_hold.valid", 64'(axi.awvalid), 64'(1));
        check("aw_hold.addr", 64'(axi.awaddr), 64'(prev_awaddr));
        check("aw_hold.len", 64'(axi.awlen), 64'(prev_awlen));
      end
      if (stall_w) begin
        check("w_hold.valid", 64'(axi.wvalid), 64'(1));
        check("w_hold.data_changed", 64'(axi.wdata != prev_wdata), 64'(0));
        check("w_hold.last", 64'(axi.wlast), 64'(prev_wlast));
      end
      stall_aw    = axi.awvalid && !axi.awready;
      stall_w     = axi.wvalid && !axi.wready;
      prev_awaddr = axi.awaddr;
      prev_awlen  = axi.awlen;
      prev_wdata  = axi.wdata;
      prev_wlast  = axi.wlast;
      if (axi.awvalid && axi.awready) begin
        aw_addr_log.push_back(axi.awaddr);
        aw_len_log.push_back(int'(axi.awlen));
        aw_cyc_log.push_back(cyc);
      end
      if (axi.wvalid && axi.wready) begin
        w_data_log.push_back(axi.wdata);
        w_last_log.push_back(axi.wlast);
        if (axi.wlast) b_owed++;
      end
      if (axi.bvalid && axi.bready) begin
        b_cyc_log.push_back(cyc);
        b_sent++;
      end
      if (return_done) done_cnt++;
    end else begin
      stall_aw = 1'b0;
      stall_w  = 1'b0;
    end
  end

  // Slave driver: readies and one B per completed W burst, changed after the edge.
  initial begin
    axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.awready = 1'b1; axi.wready = 1'b1;
      end else begin
        axi.awready = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        axi.wready  = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (b_sent < b_owed && b_sent < b_allow) begin
          axi.bvalid = 1'b1;
          axi.bresp  = (b_sent + 1 == err_at) ? 2'b10 : 2'b00;
        end else begin
          axi.bvalid = 1'b0;
          axi.bresp  = 2'b00;
        end
      end
    end
  end

  task automatic clear_log();
    aw_addr_log.delete(); aw_len_log.delete(); aw_cyc_log.delete();
    w_data_log.delete(); w_last_log.delete(); b_cyc_log.delete();
    exp_addr.delete(); exp_len.delete();
  endtask

  // Pulses start for one cycle; returns at the falling edge of cycle N+1.
  task automatic start_job(input logic [63:0] addr, input int unsigned beats, input int unsigned seed);
    clear_log();
    return_start_addr = addr;
    return_beat_num   = BW'(beats);
    return_pasid      = 9'(seed);
    for (int unsigned k = 0; k < DEPTH; k++) return_data[k*DW +: DW] = slice(seed, k);
    return_start = 1'b1;
    @(negedge clk);
    return_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned limit, output int unsigned pulses);
    int unsigned n = 0;
    int unsigned d0 = done_cnt;
    while (done_cnt == d0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".done_seen"}, 64'(done_cnt != d0), 64'(1));
    repeat (4) @(negedge clk);
    pulses = done_cnt - d0;
  endtask

  // Compares the logged AW/W traffic with exp_addr/exp_len and slice order.
  task automatic check_log(input string tag, input int unsigned seed);
    int unsigned total = 0;
    int unsigned k = 0;
    int unsigned wsel;
    logic [DW-1:0] e, g;
    check({tag, ".aw_count"}, 64'(aw_addr_log.size()), 64'(exp_addr.size()));
    for (int unsigned i = 0; i < exp_addr.size(); i++) begin
      total += exp_len[i] + 1;
      if (i < aw_addr_log.size()) begin
        check($sformatf("%s.awaddr[%0d]", tag, i), aw_addr_log[i], exp_addr[i]);
        check($sformatf("%s.awlen[%0d]", tag, i), 64'(aw_len_log[i]), 64'(exp_len[i]));
      end
    end
    check({tag, ".w_count"}, 64'(w_data_log.size()), 64'(total));
    for (int unsigned b = 0; b < exp_len.size(); b++) begin
      for (int unsigned j = 0; j <= exp_len[b]; j++) begin
        if (k < w_data_log.size()) begin
          e = slice(seed, k);
          g = w_data_log[k];
          wsel = 0;
          for (int unsigned q = DW / 64; q > 0; q--)
            if (g[(q-1)*64 +: 64] !== e[(q-1)*64 +: 64]) wsel = q - 1;
          check($sformatf("%s.wdata[%0d].q%0d", tag, k, wsel), g[wsel*64 +: 64], e[wsel*64 +: 64]);
          check($sformatf("%s.wlast[%0d]", tag, k), 64'(w_last_log[k]), 64'(j == exp_len[b]));
        end
        k++;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned pulses;
    int unsigned n;

    repeat (3) @(negedge clk);
    check("reset.awvalid", 64'(axi.awvalid), 64'(0));
    check("reset.wvalid", 64'(axi.wvalid), 64'(0));
    check("reset.wlast", 64'(axi.wlast), 64'(0));
    check("reset.awaddr", 64'(axi.awaddr), 64'(0));
    check("reset.awlen", 64'(axi.awlen), 64'(0));
    check("reset.done", 64'(return_done), 64'(0));
    check("reset.error", 64'(return_error), 64'(0));
    check("reset.busy", 64'(return_busy), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 32 beats from 0x1000: four full bursts, constant AW fields.
    start_job(64'h1000, 32, 1);
    check("t1.busy_n1", 64'(return_busy), 64'(1));
    check("t1.awvalid_n1", 64'(axi.awvalid), 64'(1));
    check("t1.wvalid_n1", 64'(axi.wvalid), 64'(0));
    check("t1.awsize", 64'(axi.awsize), 64'(7));
    check("t1.awburst", 64'(axi.awburst), 64'(1));
    check("t1.awcache", 64'(axi.awcache), 64'(3));
    check("t1.awuser", 64'(axi.awuser), 64'(1));
    check("t1.wstrb_all", 64'(&axi.wstrb), 64'(1));
    wait_done("t1", 200, pulses);
    exp_addr = '{64'h1000, 64'h1400, 64'h1800, 64'h1C00};
    exp_len  = '{7, 7, 7, 7};
    check_log("t1", 1);
    check("t1.done_pulses", 64'(pulses), 64'(1));
    check("t1.error", 64'(return_error), 64'(0));
    check("t1.busy_after", 64'(return_busy), 64'(0));

    // 5 beats starting one beat below a 4 KB line.
    start_job(64'h0F80, 5, 2);
    wait_done("t2", 200, pulses);
    exp_addr = '{64'h0F80, 64'h1000};
    exp_len  = '{0, 3};
    check_log("t2", 2);

    // B withheld: at most four bursts in flight, fifth follows the first B.
    b_allow = b_sent;
    start_job(64'h0F80, 32, 3);
    repeat (40) @(negedge clk);
    check("t3.aw_in_flight", 64'(aw_addr_log.size()), 64'(4));
    check("t3.awvalid_blocked", 64'(axi.awvalid), 64'(0));
    b_allow = b_sent + 1;
    n = 0;
    while (aw_addr_log.size() < 5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t3.fifth_aw_seen", 64'(aw_addr_log.size() >= 5), 64'(1));
    check("t3.fifth_aw_delay",
          (aw_addr_log.size() >= 5 && b_cyc_log.size() >= 1) ? 64'(aw_cyc_log[4] - b_cyc_log[0]) : 64'hFFFF,
          64'(1));
    b_allow = 1000000;
    wait_done("t3", 200, pulses);
    exp_addr = '{64'h0F80, 64'h1000, 64'h1400, 64'h1800, 64'h1C00};
    exp_len  = '{0, 7, 7, 7, 6};
    check_log("t3", 3);

    // Random AW/W stalls over the full vector.
    rand_stall = 1'b1;
    start_job(64'h2000, 32, 4);
    wait_done("t4", 600, pulses);
    rand_stall = 1'b0;
    exp_addr = '{64'h2000, 64'h2400, 64'h2800, 64'h2C00};
    exp_len  = '{7, 7, 7, 7};
    check_log("t4", 4);
    check("t4.done_pulses", 64'(pulses), 64'(1));

    // Error on the third B; a start during RUN is ignored.
    err_at = b_sent + 3;
    start_job(64'h0, 32, 5);
    repeat (4) @(negedge clk);
    return_start_addr = 64'h8000;
    return_beat_num   = BW'(1);
    return_start      = 1'b1;
    @(negedge clk);
    return_start = 1'b0;
    wait_done("t5", 200, pulses);
    err_at = 0;
    exp_addr = '{64'h0, 64'h400, 64'h800, 64'hC00};
    exp_len  = '{7, 7, 7, 7};
    check_log("t5", 5);
    check("t5.done_pulses", 64'(pulses), 64'(1));
    check("t5.error_at_end", 64'(return_error), 64'(1));
    repeat (3) @(negedge clk);
    check("t5.error_held", 64'(return_error), 64'(1));

    // Zero beats: done at N+1, start coincident with done is ignored.
    start_job(64'h5000, 0, 6);
    check("t6.done_n1", 64'(return_done), 64'(1));
    check("t6.error_cleared", 64'(return_error), 64'(0));
    check("t6.awvalid", 64'(axi.awvalid), 64'(0));
    return_start = 1'b1;
    @(negedge clk);
    return_start = 1'b0;
    check("t6.start_on_done_ignored", 64'(return_busy), 64'(0));
    start_job(64'h5000, 0, 7);
    check("t6.second_done_n1", 64'(return_done), 64'(1));
    repeat (3) @(negedge clk);
    check("t6.no_aw", 64'(aw_addr_log.size()), 64'(0));
    check("t6.no_w", 64'(w_data_log.size()), 64'(0));

    // Asynchronous reset in the middle of a burst, then a fresh job.
    start_job(64'h6000, 32, 8);
    repeat (6) @(negedge clk);
    check("t7.mid_burst_wvalid", 64'(axi.wvalid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t7.rst.awvalid", 64'(axi.awvalid), 64'(0));
    check("t7.rst.wvalid", 64'(axi.wvalid), 64'(0));
    check("t7.rst.wlast", 64'(axi.wlast), 64'(0));
    check("t7.rst.awaddr", 64'(axi.awaddr), 64'(0));
    check("t7.rst.awlen", 64'(axi.awlen), 64'(0));
    check("t7.rst.busy", 64'(return_busy), 64'(0));
    check("t7.rst.done", 64'(return_done), 64'(0));
    b_owed = 0;
    b_sent = 0;
    clear_log();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_job(64'h3000, 8, 9);
    wait_done("t7", 200, pulses);
    exp_addr = '{64'h3000};
    exp_len  = '{7};
    check_log("t7", 9);
    check("t7.done_pulses", 64'(pulses), 64'(1));
    check("t7.error", 64'(return_error), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
